// File: rtl/n64_frame_deserializer.sv
// -----------------------------------------------------------------------------
// n64_frame_deserializer
//
// Collects decoded N64 line symbols into a response frame of FRAME_BITS data
// bits followed by a stop symbol. The first BUTTON_BITS received bits form
// the button field and the rest form the joystick field. A frame is committed
// only when exactly FRAME_BITS bits are followed by a stop symbol. Short
// frames, long frames and stalled frames raise a one-cycle frame_error, and
// the published fields keep the last good frame.
//
// Symbol encoding on data[1:0]:
//   00 : no symbol this cycle
//   10 : data bit 0
//   01 : data bit 1      (the bit value is always data[0])
//   11 : stop bit
// -----------------------------------------------------------------------------
module n64_frame_deserializer #(
  parameter int FRAME_BITS     = 32,   // data bits per frame, stop excluded
  parameter int BUTTON_BITS    = 16,   // first-received bits routed to buttons
  parameter int TIMEOUT_CYCLES = 64,   // max idle cycles inside a frame
  parameter bit LSB_FIRST      = 1'b1  // 1: first bit lands in field bit 0
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic                              enable_latch,
  input  logic [1:0]                        data,
  output logic [BUTTON_BITS-1:0]            buttons,
  output logic [FRAME_BITS-BUTTON_BITS-1:0] joystick,
  output logic                              frame_valid,
  output logic                              frame_error,
  output logic                              busy,
  output logic [7:0]                        frame_count
);

  localparam int JOY_BITS  = FRAME_BITS - BUTTON_BITS;
  localparam int BIT_CNT_W = $clog2(FRAME_BITS + 1);
  localparam int TMO_CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  // Counter values at which the current symbol completes the data phase or
  // exhausts the idle allowance.
  localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(FRAME_BITS - 1);
  localparam logic [TMO_CNT_W-1:0] LAST_IDLE = TMO_CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] SYM_NONE = 2'b00;
  localparam logic [1:0] SYM_BIT0 = 2'b10;
  localparam logic [1:0] SYM_BIT1 = 2'b01;
  localparam logic [1:0] SYM_STOP = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RECV = 2'd1,
    S_STOP = 2'd2
  } state_t;

  // Elaboration-time guards on the parameter ranges.
  if (FRAME_BITS < 2 || FRAME_BITS > 64) begin : g_bad_frame_bits
    $error("n64_frame_deserializer: FRAME_BITS must be in 2..64");
  end
  if (BUTTON_BITS < 1 || BUTTON_BITS > FRAME_BITS - 1) begin : g_bad_button_bits
    $error("n64_frame_deserializer: BUTTON_BITS must be in 1..FRAME_BITS-1");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("n64_frame_deserializer: TIMEOUT_CYCLES must be >= 2");
  end

  state_t                 state;
  logic                   enable_latch_d;
  logic [FRAME_BITS-1:0]  shift_q;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic [TMO_CNT_W-1:0]   tmo_cnt;

  logic                   start;
  logic [FRAME_BITS-1:0]  shift_next;
  logic [BUTTON_BITS-1:0] frame_buttons;
  logic [JOY_BITS-1:0]    frame_joystick;

  // A frame starts on the synchronous rising edge of the level request.
  assign start = enable_latch & ~enable_latch_d;

  // Shift direction is chosen so that after exactly FRAME_BITS bits the first
  // received bit sits at frame[0] (LSB first) or frame[FRAME_BITS-1] (MSB
  // first). Only complete frames are ever committed, so the intermediate
  // alignment does not matter.
  if (LSB_FIRST) begin : g_lsb_first
    assign shift_next     = {data[0], shift_q[FRAME_BITS-1:1]};
    assign frame_buttons  = shift_q[BUTTON_BITS-1:0];
    assign frame_joystick = shift_q[FRAME_BITS-1:BUTTON_BITS];
  end else begin : g_msb_first
    assign shift_next     = {shift_q[FRAME_BITS-2:0], data[0]};
    assign frame_buttons  = shift_q[FRAME_BITS-1:JOY_BITS];
    assign frame_joystick = shift_q[JOY_BITS-1:0];
  end

  // Frame FSM with registered fields, strobes, busy flag and good-frame count.
  // NOTE: every register here is assigned with <= so all of them sample the
  // same pre-edge values; mixing in = would make results depend on statement
  // order.
  always_ff @(posedge clock) begin
    // NOTE: reset is synchronous, so reset_n must be low across a rising edge
    // to take effect; it wins over start and over any symbol.
    if (!reset_n) begin
      state          <= S_IDLE;
      enable_latch_d <= 1'b0;
      shift_q        <= '0;
      bit_cnt        <= '0;
      tmo_cnt        <= '0;
      buttons        <= '0;
      joystick       <= '0;
      frame_count    <= '0;
      frame_valid    <= 1'b0;
      frame_error    <= 1'b0;
      busy           <= 1'b0;
    end else begin
      enable_latch_d <= enable_latch;
      // Strobes are single-cycle: they drop unless re-asserted below.
      frame_valid    <= 1'b0;
      frame_error    <= 1'b0;

      if (start) begin
        // A new request abandons any frame in progress without an error and
        // swallows the symbol presented in the same cycle.
        shift_q <= '0;
        bit_cnt <= '0;
        tmo_cnt <= '0;
        state   <= S_RECV;
        busy    <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            // Symbols outside a frame are ignored.
          end

          S_RECV: begin
            case (data)
              SYM_BIT0, SYM_BIT1: begin
                shift_q <= shift_next;
                bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                tmo_cnt <= '0;
                if (bit_cnt == LAST_BIT) begin
                  state <= S_STOP;
                end
              end
              SYM_STOP: begin
                // Stop arrived before all data bits: short frame.
                frame_error <= 1'b1;
                state       <= S_IDLE;
                busy        <= 1'b0;
              end
              default: begin
                if (tmo_cnt == LAST_IDLE) begin
                  frame_error <= 1'b1;
                  state       <= S_IDLE;
                  busy        <= 1'b0;
                end else begin
                  tmo_cnt <= tmo_cnt + TMO_CNT_W'(1);
                end
              end
            endcase
          end

          S_STOP: begin
            case (data)
              SYM_STOP: begin
                // Both fields and the count change on the same edge so a
                // consumer never sees a half-updated frame.
                buttons     <= frame_buttons;
                joystick    <= frame_joystick;
                frame_count <= frame_count + 8'd1;
                frame_valid <= 1'b1;
                state       <= S_IDLE;
                busy        <= 1'b0;
              end
              SYM_BIT0, SYM_BIT1: begin
                // A data bit where the stop bit belongs: long frame.
                frame_error <= 1'b1;
                state       <= S_IDLE;
                busy        <= 1'b0;
              end
              default: begin
                if (tmo_cnt == LAST_IDLE) begin
                  frame_error <= 1'b1;
                  state       <= S_IDLE;
                  busy        <= 1'b0;
                end else begin
                  tmo_cnt <= tmo_cnt + TMO_CNT_W'(1);
                end
              end
            endcase
          end

          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // SYM_NONE is handled by the default arms above; named here for clarity of
  // the encoding table only.
  logic unused_sym_none;
  assign unused_sym_none = ^SYM_NONE;

endmodule

// File: doc/n64_frame_deserializer.md
Name: n64_frame_deserializer

Overview:
- Parametrised successor to the N64 serial-to-parallel stage. Accepts decoded line symbols from the N64 bit decoder and assembles a response frame of configurable length.
- Splits the frame into a button field and a joystick field.
- Validates the stop bit, detects short, long and stalled frames, and presents results with one-cycle valid/error strobes.
- Sits between the N64 line decoder and the button converter. Outputs hold the last good frame.

Parameters:
FRAME_BITS, 32, data bits per frame excluding stop bit (legal range 2..64)
BUTTON_BITS, 16, number of first-received bits routed to buttons (1..FRAME_BITS-1)
TIMEOUT_CYCLES, 64, max clock cycles between symbols inside a frame before abort (>=2)
LSB_FIRST, 1, 1: first received bit lands in field bit 0; 0: first received bit lands in field MSB

Ports:
clock  in  1  system clock; all logic on posedge
reset_n  in  1  synchronous, active-low reset
enable_latch  in  1  frame start request, level input; its synchronous rising edge starts a frame
data  in  2  decoded symbol: 00 none, 10 bit0, 01 bit1, 11 stop bit
buttons  out  BUTTON_BITS  button field of last good frame
joystick  out  FRAME_BITS-BUTTON_BITS  joystick field of last good frame
frame_valid  out  1  one-cycle pulse when buttons/joystick update
frame_error  out  1  one-cycle pulse on aborted/malformed frame
busy  out  1  high in RECV or STOP
frame_count  out  8  count of good frames; wraps 255->0

Behaviour:
- Reset (reset_n=0 at posedge): state=IDLE; buttons, joystick, frame_count, shift register, bit counter and timeout counter = 0; frame_valid=frame_error=busy=0; enable_latch history register = 0. Reset overrides everything, including mid-frame.
- Start: start = enable_latch & ~enable_latch_d (registered previous value).
  - Start in any state clears the shift register, bit counter and timeout counter, and enters RECV.
  - A frame in progress is abandoned silently, with no frame_error.
  - Start has priority over a same-cycle data symbol; that symbol is dropped.
- IDLE: all symbols ignored; busy=0.
- RECV:
  - 10/01: store bit (data[0]); bit counter +1; timeout counter cleared.
  - When the counter reaches FRAME_BITS, go to STOP.
  - 11 before FRAME_BITS bits (short frame): frame_error pulse, go to IDLE.
  - 00: timeout counter +1.
- STOP:
  - 11: commit frame; go to IDLE.
  - 10/01 (long frame): frame_error, go to IDLE.
  - 00: timeout counter +1.
- Timeout: when the timeout counter reaches TIMEOUT_CYCLES in RECV or STOP, assert frame_error and go to IDLE.
- Bit placement, for received bit k (k=0..FRAME_BITS-1):
  - LSB_FIRST=1: frame[k].
  - LSB_FIRST=0: frame[FRAME_BITS-1-k].
  - LSB_FIRST=1: buttons=frame[BUTTON_BITS-1:0], joystick=frame[FRAME_BITS-1:BUTTON_BITS].
  - LSB_FIRST=0: buttons=frame[FRAME_BITS-1:FRAME_BITS-BUTTON_BITS], joystick=frame[FRAME_BITS-BUTTON_BITS-1:0].
  - In both cases buttons always holds the first BUTTON_BITS received bits.
- Commit latency:
  - The stop symbol is sampled at edge N.
  - At edge N: buttons/joystick are updated, frame_count is incremented, and frame_valid=1 for exactly the cycle following edge N.
  - Outputs are never partially updated.
  - On error or abort, buttons/joystick/frame_count hold their previous values.
- frame_valid and frame_error are never high together, and each is high at most one cycle per frame.

Test Plan:
- Reset then good frame: LSB_FIRST=1; send 32 symbols for frame 0x12345A5C (bit0 first), then 11 -> one cycle after stop, buttons=0x5A5C, joystick=0x1234, frame_valid=1 for 1 cycle, frame_count=1, busy=0.
- Short frame: start, 20 bits, then 11 -> frame_error pulse; buttons/joystick keep 0x5A5C/0x1234; frame_count unchanged.
- Long frame and timeout:
  - 33rd data symbol instead of stop -> frame_error.
  - Separately, start, 5 bits, then 64 cycles of 00 -> frame_error exactly when the counter hits 64; IDLE afterwards.
- Restart mid-frame: start, 10 bits, new enable_latch rising edge coincident with a data symbol -> symbol dropped, no frame_error; the next full 32-bit frame 0xFFFF0001 + stop -> buttons=0x0001, joystick=0xFFFF.
- MSB-first and parameters: LSB_FIRST=0, FRAME_BITS=24, BUTTON_BITS=8; send bits 0xA1 then 0xBEEF MSB first + stop -> buttons=0xA1, joystick=0xBEEF.
- Wrap and reset: 256 good frames -> frame_count=0 after the last. Assert reset_n=0 mid-frame -> all outputs 0 next cycle, and remaining symbols are ignored until the next start.
